wb_fibo_ctrl: RTL and testbench
===============================

WB_FIBO_CTRL -- requirements
Module: wb_fibo_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h3000_0000, meaning window base (256-byte aligned).
REQ-002 SHALL have parameter NUM_CH, default 2, meaning Fibonacci channels served (1..4).
REQ-003 SHALL have parameter CLOCK_WIDTH, default 6, meaning per-channel clock-select width (1..8).
REQ-004 SHALL have parameter VAL_WIDTH, default 30, meaning per-channel value width (1..32).
REQ-005 SHALL have port wb_clk_i  in  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write.
REQ-008 SHALL have ports wbs_sel_i  in  4, wbs_adr_i  in  32, wbs_dat_i  in  32  byte selects, byte address, write data.
REQ-009 SHALL have ports wbs_ack_o  out  1, wbs_dat_o  out  32  acknowledge, read data.
REQ-010 SHALL have port ch_value_i  in  NUM_CH*VAL_WIDTH  channel values, channel n at [n*VAL_WIDTH +: VAL_WIDTH], synchronous to wb_clk_i.
REQ-011 SHALL have ports ch_enable_o  out  NUM_CH, ch_clock_sel_o  out  NUM_CH*CLOCK_WIDTH, irq_o  out  NUM_CH.

Function
REQ-012 Access SHALL be decoded when stb&cyc and wbs_adr_i[31:8]==BASE_ADDRESS[31:8]; other addresses SHALL never be acked.
REQ-013 wbs_ack_o SHALL assert exactly one cycle after a decoded request with ack low, for one cycle only; back-to-back requests SHALL be acked every other cycle.
REQ-014 Register map (offset): 0x00 ID RO 32'h4669626F; 0x04 CFG RO {8'h02 version, NUM_CH[7:0], CLOCK_WIDTH[7:0], VAL_WIDTH[7:0]}; 0x08 IRQ_STATUS W1C; 0x0C IRQ_ENABLE RW; 0x10 SCRATCH RW.
REQ-015 Channel n registers at 0x20+0x10*n: +0x0 CTRL RW (bit0 enable, bits[8 +: CLOCK_WIDTH] clock select); +0x4 THRESH RW (VAL_WIDTH bits); +0x8 VALUE RO.
REQ-016 Writes SHALL take effect on the ack cycle and honour wbs_sel_i per byte; bits beyond a field width SHALL be ignored and read 0.
REQ-017 Read data SHALL be registered and valid on wbs_dat_o only in the ack cycle; wbs_dat_o SHALL be 0 otherwise.
REQ-018 Reads of unmapped offsets or channels >= NUM_CH SHALL be acked returning 0; writes there SHALL be acked and discarded.
REQ-019 VALUE read SHALL return ch_value_i sampled in the request cycle, zero-extended to 32 bits.
REQ-020 Per channel, IRQ_STATUS[n] SHALL set on the cycle the registered compare (value >= THRESH) goes 0->1; a level that remains true SHALL not re-set it.
REQ-021 Set event and W1C on the same bit in the same cycle: set SHALL win.
REQ-022 irq_o[n] SHALL equal IRQ_STATUS[n] & IRQ_ENABLE[n], registered, no combinational path from Wishbone inputs.
REQ-023 Writing THRESH SHALL re-arm compare edge detection (previous-compare flag cleared).
REQ-024 ch_enable_o and ch_clock_sel_o SHALL drive directly from CTRL register flops.

Reset
REQ-025 On wb_rst_ni low, immediately: wbs_ack_o=0, wbs_dat_o=0, irq_o=0, IRQ_STATUS=0, IRQ_ENABLE=0, SCRATCH=0.
REQ-026 On reset, every channel: enable=1, clock select=1, THRESH=all ones, compare flag=0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no ack; deassertion SHALL be synchronised (two-flop release) before first ack.

Structure
REQ-028 Package wb_fibo_pkg SHALL hold register offsets, ID constant, version, CTRL field positions, channel stride.
REQ-029 Sub-module wb_fibo_chan SHALL implement one channel's CTRL/THRESH flops, compare, edge detect; instantiated NUM_CH times via generate.

Verification
REQ-030 Reset then read 0x00, 0x04 (defaults) -> 32'h4669626F, 32'h0202061E; ack one cycle after stb each time.
REQ-031 Write 0x10 data 32'hAABBCCDD sel 4'b0101, read -> 32'h00BB00DD.
REQ-032 THRESH0=100, IRQ_ENABLE=1, ch0 value 99->100->150 -> IRQ_STATUS=1 once, irq_o[0]=1; W1C 0x08=1 -> irq_o[0]=0, no re-set while value>=100.
REQ-033 W1C on 0x08 in the same cycle compare rises -> IRQ_STATUS[0] stays 1.
REQ-034 Address BASE+0x100 -> no ack; BASE+0x60 with NUM_CH=2 -> ack, data 0.
REQ-035 Write CTRL1=32'h0000_0520, then assert wb_rst_ni low mid-read -> ack never asserted; ch_enable_o[1]=1, ch_clock_sel_o[1]=1 after reset.

Source files
------------

// File: rtl/wb_fibo_pkg.sv
// Shared constants for the Wishbone Fibonacci controller: register map,
// identification words and CTRL field layout.
package wb_fibo_pkg;

  // Identification and version reported through the ID and CFG registers
  localparam logic [31:0] FIBO_ID      = 32'h4669626F;
  localparam logic [7:0]  FIBO_VERSION = 8'h02;

  // Global register offsets within the 256-byte window
  localparam logic [7:0] OFF_ID         = 8'h00;
  localparam logic [7:0] OFF_CFG        = 8'h04;
  localparam logic [7:0] OFF_IRQ_STATUS = 8'h08;
  localparam logic [7:0] OFF_IRQ_ENABLE = 8'h0C;
  localparam logic [7:0] OFF_SCRATCH    = 8'h10;

  // Channel block placement; the stride of 16 bytes lets the channel index
  // be taken straight from offset bits [7:4] after removing the base
  localparam logic [7:0] CH_BASE   = 8'h20;
  localparam logic [7:0] CH_STRIDE = 8'h10;

  // Register offsets inside one channel block
  localparam logic [3:0] CH_OFF_CTRL   = 4'h0;
  localparam logic [3:0] CH_OFF_THRESH = 4'h4;
  localparam logic [3:0] CH_OFF_VALUE  = 4'h8;

  // CTRL register field positions
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_CS_LSB = 8;

  // Which register of a channel block an access selects
  typedef enum logic [1:0] {
    CH_REG_CTRL,
    CH_REG_THRESH,
    CH_REG_VALUE,
    CH_REG_NONE
  } ch_reg_e;

  // Expand the four Wishbone byte selects into a 32-bit write mask
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_fibo_chan.sv
// One Fibonacci channel: CTRL and THRESH storage plus the threshold compare
// whose rising edge requests an interrupt.
module wb_fibo_chan
  import wb_fibo_pkg::*;
#(
  parameter int CLOCK_WIDTH = 6,
  parameter int VAL_WIDTH   = 30
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   ctrl_we,
  input  logic                   thresh_we,
  input  logic                   en_data,
  input  logic                   en_mask,
  input  logic [CLOCK_WIDTH-1:0] cs_data,
  input  logic [CLOCK_WIDTH-1:0] cs_mask,
  input  logic [VAL_WIDTH-1:0]   th_data,
  input  logic [VAL_WIDTH-1:0]   th_mask,
  input  logic [VAL_WIDTH-1:0]   value,
  output logic                   ch_enable,
  output logic [CLOCK_WIDTH-1:0] ch_clock_sel,
  output logic [31:0]            ctrl_rd,
  output logic [31:0]            thresh_rd,
  output logic                   rise
);

  logic [VAL_WIDTH-1:0] thresh;
  logic                 cmp_now;
  logic                 cmp_q;

  assign cmp_now = (value >= thresh);
  assign rise    = cmp_now & ~cmp_q;

  // CTRL/THRESH storage with byte-masked writes; a THRESH write re-arms the edge detector
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ch_enable    <= 1'b1;
      ch_clock_sel <= CLOCK_WIDTH'(1);
      thresh       <= '1;
      cmp_q        <= 1'b0;
    end else begin
      if (ctrl_we) begin
        ch_enable    <= en_mask ? en_data : ch_enable;
        ch_clock_sel <= (ch_clock_sel & ~cs_mask) | (cs_data & cs_mask);
      end
      if (thresh_we) begin
        thresh <= (thresh & ~th_mask) | (th_data & th_mask);
        cmp_q  <= 1'b0;
      end else begin
        cmp_q  <= cmp_now;
      end
    end
  end

  // Present the stored fields zero-extended at their register positions
  always_comb begin
    ctrl_rd                               = '0;
    ctrl_rd[CTRL_EN_BIT]                  = ch_enable;
    ctrl_rd[CTRL_CS_LSB +: CLOCK_WIDTH]   = ch_clock_sel;
    thresh_rd                             = '0;
    thresh_rd[VAL_WIDTH-1:0]              = thresh;
  end

endmodule

// File: rtl/wb_fibo_ctrl.sv
// Wishbone classic slave controlling NUM_CH Fibonacci channels: global
// ID/config/interrupt/scratch registers plus one register block per channel.
module wb_fibo_ctrl
  import wb_fibo_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          NUM_CH       = 2,
  parameter int          CLOCK_WIDTH  = 6,
  parameter int          VAL_WIDTH    = 30
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_we_i,
  input  logic [3:0]                    wbs_sel_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  output logic                          wbs_ack_o,
  output logic [31:0]                   wbs_dat_o,
  input  logic [NUM_CH*VAL_WIDTH-1:0]   ch_value_i,
  output logic [NUM_CH-1:0]             ch_enable_o,
  output logic [NUM_CH*CLOCK_WIDTH-1:0] ch_clock_sel_o,
  output logic [NUM_CH-1:0]             irq_o
);

  logic              rst_meta;
  logic              rst_ready;
  logic              decoded;
  logic              req;
  logic              wr_en;
  logic [7:0]        offset;
  logic [31:0]       wmask;
  logic [7:0]        ch_rel;
  logic [3:0]        ch_idx;
  logic              ch_hit;
  ch_reg_e           ch_reg;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] irq_status;
  logic [NUM_CH-1:0] irq_enable;
  logic [NUM_CH-1:0] irq_clear;
  logic [31:0]       scratch;
  logic [NUM_CH-1:0] ctrl_we;
  logic [NUM_CH-1:0] thresh_we;
  logic [NUM_CH-1:0] rise;
  logic [31:0]       ctrl_rd   [NUM_CH];
  logic [31:0]       thresh_rd [NUM_CH];

  assign offset  = wbs_adr_i[7:0];
  assign wmask   = byte_mask(wbs_sel_i);
  assign decoded = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDRESS[31:8]);
  assign req     = decoded & ~wbs_ack_o & rst_ready;
  assign wr_en   = req & wbs_we_i;

  assign ch_rel  = offset - CH_BASE;
  assign ch_idx  = ch_rel[7:4];
  assign ch_hit  = (offset >= CH_BASE) && (int'(ch_idx) < NUM_CH);

  // Identify which register of the channel block the offset points at
  always_comb begin
    ch_reg = CH_REG_NONE;
    case (ch_rel[3:0])
      CH_OFF_CTRL:   ch_reg = CH_REG_CTRL;
      CH_OFF_THRESH: ch_reg = CH_REG_THRESH;
      CH_OFF_VALUE:  ch_reg = CH_REG_VALUE;
      default:       ch_reg = CH_REG_NONE;
    endcase
  end

  // Two-flop release so the first ack never races reset deassertion
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rst_meta  <= 1'b0;
      rst_ready <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_ready <= rst_meta;
    end
  end

  // Read multiplexer, evaluated in the request cycle
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_ID:         rdata = FIBO_ID;
      OFF_CFG:        rdata = {FIBO_VERSION, 8'(NUM_CH), 8'(CLOCK_WIDTH), 8'(VAL_WIDTH)};
      OFF_IRQ_STATUS: rdata[NUM_CH-1:0] = irq_status;
      OFF_IRQ_ENABLE: rdata[NUM_CH-1:0] = irq_enable;
      OFF_SCRATCH:    rdata = scratch;
      default: begin
        if (ch_hit) begin
          for (int n = 0; n < NUM_CH; n++) begin
            if (ch_idx == 4'(n)) begin
              case (ch_reg)
                CH_REG_CTRL:   rdata = ctrl_rd[n];
                CH_REG_THRESH: rdata = thresh_rd[n];
                CH_REG_VALUE:  rdata[VAL_WIDTH-1:0] = ch_value_i[n*VAL_WIDTH +: VAL_WIDTH];
                default:       rdata = '0;
              endcase
            end
          end
        end
      end
    endcase
  end

  // Single-cycle ack with read data held only in the ack cycle
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= req ? rdata : '0;
    end
  end

  assign irq_clear = (wr_en && offset == OFF_IRQ_STATUS) ?
                     (wbs_dat_i[NUM_CH-1:0] & wmask[NUM_CH-1:0]) : '0;

  // Global registers; a compare edge outranks a simultaneous write-one-to-clear
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_status <= '0;
      irq_enable <= '0;
      scratch    <= '0;
      irq_o      <= '0;
    end else begin
      irq_status <= (irq_status & ~irq_clear) | rise;
      if (wr_en && offset == OFF_IRQ_ENABLE) begin
        irq_enable <= (irq_enable & ~wmask[NUM_CH-1:0]) | (wbs_dat_i[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
      end
      if (wr_en && offset == OFF_SCRATCH) begin
        scratch <= (scratch & ~wmask) | (wbs_dat_i & wmask);
      end
      irq_o <= irq_status & irq_enable;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
    assign ctrl_we[n]   = wr_en && ch_hit && (ch_idx == 4'(n)) && (ch_reg == CH_REG_CTRL);
    assign thresh_we[n] = wr_en && ch_hit && (ch_idx == 4'(n)) && (ch_reg == CH_REG_THRESH);

    wb_fibo_chan #(
      .CLOCK_WIDTH (CLOCK_WIDTH),
      .VAL_WIDTH   (VAL_WIDTH)
    ) u_chan (
      .wb_clk_i     (wb_clk_i),
      .wb_rst_ni    (wb_rst_ni),
      .ctrl_we      (ctrl_we[n]),
      .thresh_we    (thresh_we[n]),
      .en_data      (wbs_dat_i[CTRL_EN_BIT]),
      .en_mask      (wmask[CTRL_EN_BIT]),
      .cs_data      (wbs_dat_i[CTRL_CS_LSB +: CLOCK_WIDTH]),
      .cs_mask      (wmask[CTRL_CS_LSB +: CLOCK_WIDTH]),
      .th_data      (wbs_dat_i[VAL_WIDTH-1:0]),
      .th_mask      (wmask[VAL_WIDTH-1:0]),
      .value        (ch_value_i[n*VAL_WIDTH +: VAL_WIDTH]),
      .ch_enable    (ch_enable_o[n]),
      .ch_clock_sel (ch_clock_sel_o[n*CLOCK_WIDTH +: CLOCK_WIDTH]),
      .ctrl_rd      (ctrl_rd[n]),
      .thresh_rd    (thresh_rd[n]),
      .rise         (rise[n])
    );
  end

endmodule

// File: tb/tb_wb_fibo_ctrl.sv
// Self-checking bench for wb_fibo_ctrl: directed register-map, interrupt and
// reset scenarios plus a randomized read/write phase against a register model.
module tb_wb_fibo_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int NUM_CH = 2;
  localparam int CW     = 6;
  localparam int VW     = 30;

  logic                 wb_clk_i  = 1'b0;
  logic                 wb_rst_ni = 1'b1;
  logic                 wbs_stb_i = 1'b0;
  logic                 wbs_cyc_i = 1'b0;
  logic                 wbs_we_i  = 1'b0;
  logic [3:0]           wbs_sel_i = 4'h0;
  logic [31:0]          wbs_adr_i = '0;
  logic [31:0]          wbs_dat_i = '0;
  logic                 wbs_ack_o;
  logic [31:0]          wbs_dat_o;
  logic [NUM_CH*VW-1:0] ch_value_i = '0;
  logic [NUM_CH-1:0]    ch_enable_o;
  logic [NUM_CH*CW-1:0] ch_clock_sel_o;
  logic [NUM_CH-1:0]    irq_o;

  int errors = 0;
  int checks = 0;

  wb_fibo_ctrl #(
    .BASE_ADDRESS (BASE),
    .NUM_CH       (NUM_CH),
    .CLOCK_WIDTH  (CW),
    .VAL_WIDTH    (VW)
  ) dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_ni      (wb_rst_ni),
    .wbs_stb_i      (wbs_stb_i),
    .wbs_cyc_i      (wbs_cyc_i),
    .wbs_we_i       (wbs_we_i),
    .wbs_sel_i      (wbs_sel_i),
    .wbs_adr_i      (wbs_adr_i),
    .wbs_dat_i      (wbs_dat_i),
    .wbs_ack_o      (wbs_ack_o),
    .wbs_dat_o      (wbs_dat_o),
    .ch_value_i     (ch_value_i),
    .ch_enable_o    (ch_enable_o),
    .ch_clock_sel_o (ch_clock_sel_o),
    .irq_o          (irq_o)
  );

  // Free-running 100 MHz clock
  always #5 wb_clk_i = ~wb_clk_i;

  // Hard time limit so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One Wishbone transaction; lat is the number of cycles to ack or -1 if none
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    lat   = -1;
    rdata = '0;
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    for (int c = 1; c <= 8; c++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        lat   = c;
        rdata = wbs_dat_o;
        break;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge wb_clk_i); #1;
    end
  endtask

  // Spec-level register update: byte-select merge, then drop bits outside the field
  function automatic logic [31:0] mergeReg(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] sel, input logic [31:0] field);
    logic [31:0] bm;
    bm = '0;
    for (int b = 0; b < 4; b++) if (sel[b]) bm[8*b +: 8] = 8'hFF;
    return ((old & ~bm) | (d & bm)) & field;
  endfunction

  logic [31:0] rd;
  int          lat;
  int          acks;
  int          k;
  logic        rw;
  logic [31:0] wdat;
  logic [3:0]  wsel;
  logic [31:0] exp_rd;
  logic [7:0]  off_tab   [8];
  logic [31:0] field_tab [8];
  logic [31:0] m_reg     [8];
  logic [29:0] v0;
  logic [29:0] v1;

  initial begin
    off_tab   = '{8'h10, 8'h0C, 8'h20, 8'h24, 8'h28, 8'h30, 8'h34, 8'h38};
    field_tab = '{32'hFFFF_FFFF, 32'h3, 32'h3F01, 32'h3FFF_FFFF, 32'h0, 32'h3F01, 32'h3FFF_FFFF, 32'h0};
    m_reg     = '{32'h0, 32'h0, 32'h101, 32'h3FFF_FFFF, 32'h0, 32'h101, 32'h3FFF_FFFF, 32'h0};

    // Reset: outputs must clear immediately
    #2 wb_rst_ni = 1'b0;
    #1;
    checkOutput("reset_ack", 32'(wbs_ack_o), 32'h0);
    checkOutput("reset_dat", wbs_dat_o, 32'h0);
    checkOutput("reset_irq", 32'(irq_o), 32'h0);
    checkOutput("reset_enable", 32'(ch_enable_o), 32'h3);
    checkOutput("reset_clock_sel", 32'(ch_clock_sel_o), 32'h041);
    waitCycles(3);
    wb_rst_ni = 1'b1;
    waitCycles(4);

    // Identification and configuration reads
    applyStimulus(1'b0, BASE + 32'h00, '0, 4'hF, rd, lat);
    checkOutput("id_latency", 32'(lat), 32'd1);
    checkOutput("id_value", rd, 32'h4669626F);
    waitCycles(1);
    checkOutput("dat_zero_after_ack", wbs_dat_o, 32'h0);
    applyStimulus(1'b0, BASE + 32'h04, '0, 4'hF, rd, lat);
    checkOutput("cfg_latency", 32'(lat), 32'd1);
    checkOutput("cfg_value", rd, 32'h0202061E);

    // Byte-masked scratch write
    applyStimulus(1'b1, BASE + 32'h10, 32'hAABBCCDD, 4'b0101, rd, lat);
    m_reg[0] = mergeReg(m_reg[0], 32'hAABBCCDD, 4'b0101, field_tab[0]);
    applyStimulus(1'b0, BASE + 32'h10, '0, 4'hF, rd, lat);
    checkOutput("scratch_bytesel", rd, 32'h00BB00DD);

    // Strobe held continuously: acks alternate with idle cycles
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    checkOutput("back_to_back_acks", 32'(acks), 32'd4);

    // Out-of-window and missing channel
    applyStimulus(1'b0, BASE + 32'h100, '0, 4'hF, rd, lat);
    checkOutput("outside_window_no_ack", 32'(lat), 32'hFFFF_FFFF);
    applyStimulus(1'b1, BASE + 32'h60, 32'hFFFF_FFFF, 4'hF, rd, lat);
    checkOutput("missing_ch_write_ack", 32'(lat), 32'd1);
    applyStimulus(1'b0, BASE + 32'h60, '0, 4'hF, rd, lat);
    checkOutput("missing_ch_read_ack", 32'(lat), 32'd1);
    checkOutput("missing_ch_read_zero", rd, 32'h0);

    // Randomized register traffic against the model
    for (int i = 0; i < 40; i++) begin
      k    = $urandom_range(0, 7);
      rw   = 1'($urandom_range(0, 1));
      wdat = $urandom;
      wsel = 4'($urandom_range(0, 15));
      v0   = 30'($urandom);
      v1   = 30'($urandom);
      ch_value_i = {v1, v0};
      if (k == 4)      exp_rd = {2'b00, v0};
      else if (k == 7) exp_rd = {2'b00, v1};
      else             exp_rd = m_reg[k];
      applyStimulus(rw, BASE + {24'h0, off_tab[k]}, wdat, wsel, rd, lat);
      checkOutput("rand_latency", 32'(lat), 32'd1);
      if (rw) begin
        m_reg[k] = mergeReg(m_reg[k], wdat, wsel, field_tab[k]);
      end else begin
        checkOutput("rand_read", rd, exp_rd);
      end
      checkOutput("rand_enable", 32'(ch_enable_o), {30'h0, m_reg[5][0], m_reg[2][0]});
      checkOutput("rand_clock_sel", 32'(ch_clock_sel_o), {20'h0, m_reg[5][13:8], m_reg[2][13:8]});
    end

    // Threshold interrupt on channel 0
    ch_value_i = '0;
    ch_value_i[0 +: VW] = 30'd99;
    applyStimulus(1'b1, BASE + 32'h34, 32'h3FFF_FFFF, 4'hF, rd, lat);
    applyStimulus(1'b1, BASE + 32'h24, 32'd100, 4'hF, rd, lat);
    applyStimulus(1'b1, BASE + 32'h08, 32'hF, 4'hF, rd, lat);
    applyStimulus(1'b1, BASE + 32'h0C, 32'h1, 4'hF, rd, lat);
    waitCycles(3);
    applyStimulus(1'b0, BASE + 32'h08, '0, 4'hF, rd, lat);
    checkOutput("irq_status_below", rd, 32'h0);
    checkOutput("irq_o_below", 32'(irq_o), 32'h0);
    ch_value_i[0 +: VW] = 30'd100;
    waitCycles(3);
    applyStimulus(1'b0, BASE + 32'h08, '0, 4'hF, rd, lat);
    checkOutput("irq_status_at_thresh", rd, 32'h1);
    checkOutput("irq_o_at_thresh", 32'(irq_o), 32'h1);
    ch_value_i[0 +: VW] = 30'd150;
    waitCycles(3);
    applyStimulus(1'b1, BASE + 32'h08, 32'h1, 4'hF, rd, lat);
    waitCycles(2);
    checkOutput("irq_o_after_w1c", 32'(irq_o), 32'h0);
    waitCycles(5);
    applyStimulus(1'b0, BASE + 32'h08, '0, 4'hF, rd, lat);
    checkOutput("irq_no_reset_on_level", rd, 32'h0);

    // Compare edge and write-one-to-clear landing on the same clock
    ch_value_i[0 +: VW] = 30'd50;
    waitCycles(3);
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = BASE + 32'h08; wbs_dat_i = 32'h1; wbs_sel_i = 4'hF;
    ch_value_i[0 +: VW] = 30'd200;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        lat = c;
        break;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    checkOutput("w1c_collide_latency", 32'(lat), 32'd1);
    applyStimulus(1'b0, BASE + 32'h08, '0, 4'hF, rd, lat);
    checkOutput("set_wins_over_w1c", rd, 32'h1);

    // CTRL1 write, then reset in the middle of a read
    applyStimulus(1'b1, BASE + 32'h30, 32'h0000_0520, 4'hF, rd, lat);
    checkOutput("ctrl1_enable", 32'(ch_enable_o[1]), 32'h0);
    checkOutput("ctrl1_clock_sel", 32'(ch_clock_sel_o[CW +: CW]), 32'h5);
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE;
    #2 wb_rst_ni = 1'b0;
    #1;
    checkOutput("midread_reset_irq", 32'(irq_o), 32'h0);
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
    end
    checkOutput("midread_no_ack", 32'(acks), 32'd0);
    checkOutput("midread_dat_zero", wbs_dat_o, 32'h0);
    checkOutput("post_reset_enable1", 32'(ch_enable_o[1]), 32'h1);
    checkOutput("post_reset_clock_sel1", 32'(ch_clock_sel_o[CW +: CW]), 32'h1);

    // Release with the strobe still held: ack only after the release settles
    wb_rst_ni = 1'b1;
    acks = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
    end
    checkOutput("release_sync_no_early_ack", 32'(acks), 32'd0);
    lat = -1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        lat = c;
        rd  = wbs_dat_o;
        break;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    checkOutput("release_ack_seen", 32'(lat > 0), 32'h1);
    checkOutput("release_read_id", rd, 32'h4669626F);
    applyStimulus(1'b0, BASE + 32'h10, '0, 4'hF, rd, lat);
    checkOutput("scratch_after_reset", rd, 32'h0);
    applyStimulus(1'b0, BASE + 32'h0C, '0, 4'hF, rd, lat);
    checkOutput("irq_enable_after_reset", rd, 32'h0);
    applyStimulus(1'b0, BASE + 32'h34, '0, 4'hF, rd, lat);
    checkOutput("thresh1_after_reset", rd, 32'h3FFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
